// File: rtl/dff_link_pkg.sv
// Shared definitions for the dff_link delay line.
// Holds default geometry and the word type used by the default chain.
package dff_link_pkg;

   localparam int DFF_LINK_WIDTH = 8;
   localparam int DFF_LINK_DEPTH = 4;

   typedef logic [DFF_LINK_WIDTH-1:0] dff_word_t;

endpackage : dff_link_pkg

// File: rtl/dff_stage_8bits.sv
// One register stage of the delay line with synchronous active-low clear.
// Ports: CLK clock, RST sync active-low clear, d stage input, q stage output.
module dff_stage_8bits
   import dff_link_pkg::*;
#(
   parameter int WIDTH = DFF_LINK_WIDTH
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] data_d;
   logic [WIDTH-1:0] data_q;

   always_comb begin
      data_d = d;
   end

   always_ff @(posedge CLK) begin
      if (!RST) begin
         data_q <= '0;
      end else begin
         data_q <= data_d;
      end
   end

   assign q = data_q;

endmodule : dff_stage_8bits

// File: rtl/dff_link_4_8bits.sv
// Fixed-latency delay line: DEPTH chained WIDTH-bit register stages.
// Ports: CLK, RST (sync active-low), input_data in, output_data = last stage.
module dff_link_4_8bits
   import dff_link_pkg::*;
#(
   parameter int WIDTH = DFF_LINK_WIDTH,
   parameter int DEPTH = DFF_LINK_DEPTH
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [WIDTH-1:0] input_data,
   output logic [WIDTH-1:0] output_data
);

   // A zero-length chain would silently become a wire; refuse it.
   if (DEPTH < 1) begin : g_bad_depth
      $error("dff_link_4_8bits: DEPTH must be at least 1");
   end

   // tap[0] is the input; tap[i+1] is the output of stage i.
   logic [WIDTH-1:0] tap [DEPTH+1];

   assign tap[0] = input_data;

   for (genvar i = 0; i < DEPTH; i++) begin : g_stage
      dff_stage_8bits #(
         .WIDTH (WIDTH)
      ) u_stage (
         .CLK (CLK),
         .RST (RST),
         .d   (tap[i]),
         .q   (tap[i+1])
      );
   end

   assign output_data = tap[DEPTH];

endmodule : dff_link_4_8bits

// File: tb/tb_dff_link_4_8bits.sv
// Self-checking bench for dff_link_4_8bits (default and 16x1 builds).
// Random and directed stimulus against a queue-based reference model.
module tb_dff_link_4_8bits;

   localparam int D = 4;

   logic        CLK;
   logic        RST;
   logic [7:0]  din;
   logic [7:0]  dout;
   logic [15:0] din16;
   logic [15:0] dout16;

   int errors = 0;
   int checks = 0;

   // Reference: queue holds the stage contents, newest at front.
   logic [7:0]  mq [$];
   logic [7:0]  exp8;
   logic [15:0] prev16;

   dff_link_4_8bits dut (
      .CLK         (CLK),
      .RST         (RST),
      .input_data  (din),
      .output_data (dout)
   );

   dff_link_4_8bits #(
      .WIDTH (16),
      .DEPTH (1)
   ) dut16 (
      .CLK         (CLK),
      .RST         (RST),
      .input_data  (din16),
      .output_data (dout16)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Drive on the falling edge, apply one rising edge, update the model.
   task automatic tick(input logic [7:0] d, input logic r,
                       input logic [15:0] d16);
      @(negedge CLK);
      din   = d;
      RST   = r;
      din16 = d16;
      @(posedge CLK);
      #1;
      if (!r) begin
         mq = {};
         for (int i = 0; i < D; i++) mq.push_back(8'h00);
         prev16 = 16'h0000;
      end else begin
         mq.push_front(d);
         void'(mq.pop_back());
         prev16 = d16;
      end
      exp8 = mq[D-1];
   endtask

   task automatic test_reset();
      for (int k = 0; k < 3; k++) begin
         tick(8'hFF, 1'b0, 16'hFFFF);
         checks++;
         if (dout !== 8'h00) begin
            errors++;
            $display("FAIL reset_out got=%h exp=00", dout);
         end
         for (int t = 1; t <= D; t++) begin
            checks++;
            if (dut.tap[t] !== 8'h00) begin
               errors++;
               $display("FAIL reset_tap%0d got=%h exp=00", t, dut.tap[t]);
            end
         end
         checks++;
         if (dout16 !== 16'h0000) begin
            errors++;
            $display("FAIL reset_out16 got=%h exp=0000", dout16);
         end
      end
   endtask

   task automatic test_latency();
      logic [7:0] want [5];
      want = '{8'h00, 8'h00, 8'h00, 8'hA5, 8'h00};
      for (int k = 0; k < 5; k++) begin
         tick((k == 0) ? 8'hA5 : 8'h00, 1'b1, 16'h0);
         checks++;
         if (dout !== want[k] || dout !== exp8) begin
            errors++;
            $display("FAIL latency_e%0d got=%h exp=%h", k + 1, dout, want[k]);
         end
      end
   endtask

   task automatic test_stream();
      for (int k = 1; k <= 12; k++) begin
         tick(8'(k), 1'b1, 16'h0);
         checks++;
         if (dout !== exp8) begin
            errors++;
            $display("FAIL stream_seq got=%h exp=%h", dout, exp8);
         end
      end
      for (int k = 0; k < 1000; k++) begin
         tick(8'($urandom), 1'b1, 16'h0);
         checks++;
         if (dout !== exp8) begin
            errors++;
            $display("FAIL stream_rand got=%h exp=%h", dout, exp8);
         end
      end
   endtask

   task automatic test_mid_reset();
      for (int k = 0; k < 4; k++) tick(8'h10 + 8'(k), 1'b1, 16'h0);
      tick(8'h77, 1'b0, 16'h0);
      checks++;
      if (dout !== 8'h00) begin
         errors++;
         $display("FAIL midrst_clear got=%h exp=00", dout);
      end
      for (int k = 0; k < 8; k++) begin
         tick(8'h20 + 8'(k), 1'b1, 16'h0);
         checks++;
         if (dout !== exp8 || (dout >= 8'h10 && dout <= 8'h13)) begin
            errors++;
            $display("FAIL midrst_after got=%h exp=%h", dout, exp8);
         end
      end
   endtask

   task automatic test_back_to_back();
      tick(8'h3C, 1'b1, 16'h0);
      tick(8'hC3, 1'b0, 16'h0);
      checks++;
      if (dout !== 8'h00) begin
         errors++;
         $display("FAIL b2b_clear got=%h exp=00", dout);
      end
      for (int k = 0; k < 6; k++) begin
         tick(8'($urandom), 1'b1, 16'h0);
         checks++;
         if (dout !== exp8) begin
            errors++;
            $display("FAIL b2b_resume got=%h exp=%h", dout, exp8);
         end
      end
   endtask

   task automatic test_extremes();
      logic [7:0] pat [4];
      pat = '{8'h00, 8'hFF, 8'h55, 8'hAA};
      for (int k = 0; k < 16; k++) begin
         tick(pat[k % 4], 1'b1, 16'h0);
         checks++;
         if (dout !== exp8) begin
            errors++;
            $display("FAIL extremes got=%h exp=%h", dout, exp8);
         end
         if (k >= D - 1) begin
            checks++;
            if (dout !== pat[(k - (D - 1)) % 4]) begin
               errors++;
               $display("FAIL extremes_pat got=%h exp=%h",
                        dout, pat[(k - (D - 1)) % 4]);
            end
         end
      end
   endtask

   task automatic test_param();
      for (int k = 0; k < 20; k++) begin
         tick(8'h00, 1'b1, 16'($urandom));
         checks++;
         if (dout16 !== prev16) begin
            errors++;
            $display("FAIL param16 got=%h exp=%h", dout16, prev16);
         end
      end
      tick(8'h00, 1'b1, 16'hFFFF);
      tick(8'h00, 1'b0, 16'h1234);
      checks++;
      if (dout16 !== 16'h0000) begin
         errors++;
         $display("FAIL param16_rst got=%h exp=0000", dout16);
      end
      tick(8'h00, 1'b1, 16'hBEEF);
      checks++;
      if (dout16 !== 16'hBEEF) begin
         errors++;
         $display("FAIL param16_rel got=%h exp=beef", dout16);
      end
   endtask

   initial begin
      RST   = 1'b0;
      din   = 8'h00;
      din16 = 16'h0;
      test_reset();
      test_latency();
      test_stream();
      test_mid_reset();
      test_back_to_back();
      test_extremes();
      test_param();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_dff_link_4_8bits
